// File: rtl/led_flash_multi_if.sv
// led_flash_multi_if
//   Groups the key/switch inputs and the LED/mode outputs of the LED
//   pattern controller into one bundle.
//   Signals:
//     key    step request from the board key, asynchronous level
//     sel    sub-mode select switch, sampled live
//     led    N_CH-wide LED drive, 1 = lit
//     state  current mode: 0 OFF, 1 ON, 2 BLINK, 3 CHASE
//   Modports:
//     master  drives key/sel, observes led/state (board side, testbench)
//     slave   the controller itself
interface led_flash_multi_if #(
  parameter int N_CH = 4
);
  logic            key;
  logic            sel;
  logic [N_CH-1:0] led;
  logic [1:0]      state;

  modport master (
    output key,
    output sel,
    input  led,
    input  state
  );

  modport slave (
    input  key,
    input  sel,
    output led,
    output state
  );
endinterface

// File: rtl/led_flash_multi.sv
// led_flash_multi
//   Multi-channel LED pattern controller. A synchronised key press steps
//   a four-mode machine OFF -> ON -> BLINK -> CHASE -> OFF. In BLINK the
//   select switch chooses in-phase or alternating (even/odd) blinking; in
//   CHASE it chooses the running direction. A shared prescaler of DIV
//   clocks paces the pattern.
//   Parameters:
//     N_CH  number of LED channels (>= 1)
//     DIV   clock cycles per pattern tick (>= 1)
//   Ports:
//     clk    system clock, all state on the rising edge
//     rst_n  asynchronous active-low reset
//     bus    led_flash_multi_if slave modport (key, sel in; led, state out)
module led_flash_multi #(
  parameter int N_CH = 4,
  parameter int DIV  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  led_flash_multi_if.slave    bus
);

  localparam int CW = (DIV  > 1) ? $clog2(DIV)  : 1;
  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_ON    = 2'd1,
    ST_BLINK = 2'd2,
    ST_CHASE = 2'd3
  } state_t;

  logic            k1_q, k1_d;
  logic            k2_q, k2_d;
  logic            k3_q, k3_d;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ph_q, ph_d;
  logic [PW-1:0]   pos_q, pos_d;
  logic [N_CH-1:0] led_q, led_d;

  logic            press;
  logic            tick;

  // Next-state logic. k1/k2 resynchronise the key and k3 remembers the
  // previous synchronised level, so a press is a single-cycle rising edge
  // no matter how long the key is held. A press restarts the prescaler
  // and the pattern, and swallows any tick falling on the same cycle so
  // the new mode always shows its entry pattern for a full DIV cycles.
  always_comb begin
    k1_d    = bus.key;
    k2_d    = k1_q;
    k3_d    = k2_q;
    press   = k2_q & ~k3_q;
    tick    = (cnt_q == CW'(DIV - 1));

    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    pos_d   = pos_q;

    if (press) begin
      state_d = state_t'(state_q + 2'd1);
      cnt_d   = '0;
      ph_d    = 1'b1;
      pos_d   = '0;
    end else begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (tick) begin
        ph_d = ~ph_q;
        if (state_q == ST_CHASE) begin
          if (bus.sel) begin
            pos_d = (pos_q == '0) ? PW'(N_CH - 1) : pos_q - 1'b1;
          end else begin
            pos_d = (pos_q == PW'(N_CH - 1)) ? '0 : pos_q + 1'b1;
          end
        end
      end
    end
  end

  // LED pattern is built from the upcoming mode/phase/position so the LEDs
  // and the reported mode change on the same edge. sel is taken live,
  // which lets a BLINK sub-mode switch show up on the very next edge
  // without disturbing the phase.
  always_comb begin
    led_d = '0;
    case (state_d)
      ST_OFF: led_d = '0;
      ST_ON:  led_d = '1;
      ST_BLINK: begin
        for (int i = 0; i < N_CH; i++) begin
          if (bus.sel && ((i % 2) != 0)) begin
            led_d[i] = ~ph_d;
          end else begin
            led_d[i] = ph_d;
          end
        end
      end
      ST_CHASE: begin
        for (int i = 0; i < N_CH; i++) begin
          led_d[i] = (pos_d == PW'(i));
        end
      end
      default: led_d = '0;
    endcase
  end

  // State registers; reset clears everything immediately, including the
  // key synchroniser so a key edge seen during reset is forgotten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k1_q    <= 1'b0;
      k2_q    <= 1'b0;
      k3_q    <= 1'b0;
      state_q <= ST_OFF;
      cnt_q   <= '0;
      ph_q    <= 1'b0;
      pos_q   <= '0;
      led_q   <= '0;
    end else begin
      k1_q    <= k1_d;
      k2_q    <= k2_d;
      k3_q    <= k3_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      pos_q   <= pos_d;
      led_q   <= led_d;
    end
  end

  assign bus.led   = led_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_led_flash_multi.sv
// tb_led_flash_multi
//   Directed and random stimulus for led_flash_multi (N_CH=4, DIV=4),
//   compared each cycle against a behavioural model of the mode machine.
module tb_led_flash_multi;

  localparam int N_CH = 4;
  localparam int DIV  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int testsRun  = 0;
  int failCount = 0;

  // Behavioural model: mode number, blink phase, chase position, cycles
  // since the pattern epoch, and the key level seen at recent edges
  // (index 0 = this edge, 3 = three edges ago).
  int mMode;
  int mPh;
  int mPos;
  int mCnt;
  bit keyHist[$];

  logic [3:0] chaseSeq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

  led_flash_multi_if #(.N_CH(N_CH)) bus ();

  led_flash_multi #(
    .N_CH(N_CH),
    .DIV (DIV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [3:0] modelLed(input logic selNow);
    case (mMode)
      0:       return 4'b0000;
      1:       return 4'b1111;
      2:       return selNow ? ((mPh != 0) ? 4'b0101 : 4'b1010)
                             : ((mPh != 0) ? 4'b1111 : 4'b0000);
      default: return 4'b0001 << mPos;
    endcase
  endfunction

  task automatic modelReset();
    mMode = 0;
    mPh   = 0;
    mPos  = 0;
    mCnt  = 0;
    keyHist.delete();
    repeat (4) keyHist.push_front(1'b0);
  endtask

  // One rising edge of the model: a press is a key seen high two edges
  // ago after being low three edges ago.
  task automatic modelEdge(input bit keyNow, input bit selNow);
    bit press;
    keyHist.push_front(keyNow);
    void'(keyHist.pop_back());
    press = keyHist[2] && !keyHist[3];
    if (press) begin
      mMode = (mMode + 1) % 4;
      mPh   = 1;
      mPos  = 0;
      mCnt  = 0;
    end else begin
      if (mCnt == DIV - 1) begin
        mPh = 1 - mPh;
        if (mMode == 3) begin
          mPos = selNow ? (mPos + N_CH - 1) % N_CH : (mPos + 1) % N_CH;
        end
      end
      mCnt = (mCnt + 1) % DIV;
    end
  endtask

  task automatic compareVal(input string tag, input logic [7:0] obsVal,
                            input logic [7:0] expVal);
    testsRun++;
    assert (obsVal === expVal) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 'h%0h expected 'h%0h", tag, obsVal, expVal);
    end
  endtask

  task automatic checkOutput(input string tag);
    compareVal({tag, "/state"}, {6'd0, bus.state}, 8'(mMode));
    compareVal({tag, "/led"}, {4'd0, bus.led}, {4'd0, modelLed(bus.sel)});
  endtask

  task automatic checkConst(input string tag, input logic [1:0] st,
                            input logic [3:0] led);
    compareVal({tag, "/state_k"}, {6'd0, bus.state}, {6'd0, st});
    compareVal({tag, "/led_k"}, {4'd0, bus.led}, {4'd0, led});
  endtask

  // Called at a falling edge; drives inputs, advances one rising edge,
  // checks, and returns at the next falling edge.
  task automatic applyStimulus(input logic k, input logic s, input string tag);
    bus.key = k;
    bus.sel = s;
    @(posedge clk);
    modelEdge(k, s);
    #1;
    checkOutput(tag);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic s, input string tag);
    repeat (n) applyStimulus(1'b0, s, tag);
  endtask

  // Single-cycle key pulse; returns just after the edge where the mode steps.
  task automatic pulse(input logic s, input string tag);
    applyStimulus(1'b1, s, tag);
    applyStimulus(1'b0, s, tag);
    applyStimulus(1'b0, s, tag);
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic asyncReset(input string tag);
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkConst(tag, 2'd0, 4'b0000);
    @(negedge clk);
    checkOutput(tag);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.key = 1'b0;
    bus.sel = 1'b0;
    rst_n   = 1'b0;
    modelReset();

    repeat (3) @(negedge clk);
    checkConst("reset_active", 2'd0, 4'b0000);
    rst_n = 1'b1;
    idle(20, 1'b0, "reset_hold");
    checkConst("reset_hold_end", 2'd0, 4'b0000);

    applyStimulus(1'b1, 1'b0, "pulse_e1");
    checkConst("pulse_e1", 2'd0, 4'b0000);
    applyStimulus(1'b0, 1'b0, "pulse_e2");
    checkConst("pulse_e2", 2'd0, 4'b0000);
    applyStimulus(1'b0, 1'b0, "pulse_e3");
    checkConst("pulse_e3", 2'd1, 4'b1111);
    idle(3, 1'b0, "gap");
    pulse(1'b0, "step_blink");
    checkConst("to_blink", 2'd2, 4'b1111);
    idle(3, 1'b0, "gap");
    pulse(1'b0, "step_chase");
    checkConst("to_chase", 2'd3, 4'b0001);
    idle(3, 1'b0, "gap");
    pulse(1'b0, "step_off");
    checkConst("to_off", 2'd0, 4'b0000);
    repeat (10) applyStimulus(1'b1, 1'b0, "hold");
    idle(5, 1'b0, "hold_release");
    checkConst("hold_once", 2'd1, 4'b1111);

    pulse(1'b0, "blink_enter");
    checkConst("blink_entry", 2'd2, 4'b1111);
    idle(3, 1'b0, "blink_wait");
    checkConst("blink_pre_tick", 2'd2, 4'b1111);
    idle(1, 1'b0, "blink_wait");
    checkConst("blink_tick", 2'd2, 4'b0000);
    applyStimulus(1'b0, 1'b1, "blink_sel");
    checkConst("blink_alt", 2'd2, 4'b1010);
    idle(3, 1'b1, "blink_alt_wait");
    checkConst("blink_alt_tick", 2'd2, 4'b0101);

    pulse(1'b0, "chase_enter");
    checkConst("chase_entry", 2'd3, 4'b0001);
    for (int k = 0; k < 4; k++) begin
      idle(4, 1'b0, "chase_run");
      checkConst("chase_step", 2'd3, chaseSeq[k]);
    end
    idle(3, 1'b1, "chase_rev_wait");
    checkConst("chase_rev_hold", 2'd3, 4'b0001);
    idle(1, 1'b1, "chase_rev_wait");
    checkConst("chase_rev_wrap", 2'd3, 4'b1000);

    pulse(1'b0, "to_off2");
    pulse(1'b0, "to_on2");
    pulse(1'b0, "to_blink2");
    idle(5, 1'b0, "align");
    applyStimulus(1'b1, 1'b0, "tick_press");
    applyStimulus(1'b0, 1'b0, "tick_press");
    applyStimulus(1'b0, 1'b0, "tick_press");
    checkConst("tick_press_entry", 2'd3, 4'b0001);
    idle(3, 1'b0, "tick_press_wait");
    checkConst("tick_press_hold", 2'd3, 4'b0001);
    idle(1, 1'b0, "tick_press_wait");
    checkConst("tick_press_step", 2'd3, 4'b0010);

    idle(6, 1'b0, "pre_reset");
    asyncReset("mid_chase_reset");
    pulse(1'b0, "post_reset");
    checkConst("post_reset", 2'd1, 4'b1111);

    // Key activity while reset is held must be dropped.
    rst_n = 1'b0;
    modelReset();
    bus.key = 1'b1;
    @(negedge clk);
    bus.key = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(5, 1'b0, "key_in_reset");
    checkConst("key_in_reset", 2'd0, 4'b0000);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        asyncReset("rand_reset");
      end else begin
        applyStimulus(logic'($urandom_range(0, 5) == 0),
                      logic'($urandom_range(0, 1)), "random");
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
